// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared display constants and types
// for the seven-segment scan controller
package seg_scan_ctrl_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // active-low g..a patterns, entry n is hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [15:0] val;
    logic [1:0]  sel;
  } snap_t;

  // digit k is a leading zero when every nibble from k upward is zero;
  // digit 0 always shows
  function automatic logic lz_blank(
    input logic [15:0] v,
    input logic [1:0]  k
  );
    logic [15:0] hi;
    hi = v >> {k, 2'b00};
    return (k != 2'd0) && (hi == 16'h0000);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// hex_to_seg: combinational 4-bit to active-low
// seven-segment decoder
module hex_to_seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scan controller
// frame-snapshotted source select, hex decode, lz blanking
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 262144
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [15:0]       src0,
  input  logic [15:0]       src1,
  input  logic [15:0]       src2,
  input  logic [15:0]       src3,
  input  logic [1:0]        select_reg,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] pos_ctrl,
  output logic [7:0]        num_ctrl
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic          tick_q;
  logic [1:0]    ptr;
  snap_t         snap;
  logic [15:0]   src_sel;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          blank;

  assign tick = (cnt == LAST);

  // slot timer, wraps every SCAN_DIV cycles
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // live source mux, only consumed at a frame boundary
  always_comb begin
    src_sel = src0;
    unique case (select_reg)
      2'd0: src_sel = src0;
      2'd1: src_sel = src1;
      2'd2: src_sel = src2;
      2'd3: src_sel = src3;
    endcase
  end

  // digit pointer; snapshot source and select on the wrap to digit 0
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ptr    <= 2'd3;
      snap   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
      if (tick) begin
        ptr <= ptr + 2'd1;
        if (ptr == 2'd3) begin
          snap <= '{val: src_sel, sel: select_reg};
        end
      end
    end
  end

  assign nib   = 4'(snap.val >> {ptr, 2'b00});
  assign blank = blank_lz && lz_blank(snap.val, ptr);

  hex_to_seg u_hex (
    .nib (nib),
    .seg (seg)
  );

  // output registers, reloaded one cycle after each tick
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pos_ctrl <= 4'hF;
      num_ctrl <= 8'hFF;
    end else if (tick_q) begin
      pos_ctrl <= ~(4'b0001 << ptr);
      num_ctrl <= {(ptr != snap.sel), blank ? SEG_BLANK : seg};
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl
// SCAN_DIV = 4, one frame = 16 cycles
module tb_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] src0 = 16'h0;
  logic [15:0] src1 = 16'h0;
  logic [15:0] src2 = 16'h0;
  logic [15:0] src3 = 16'h0;
  logic [1:0]  select_reg = 2'd0;
  logic        blank_lz = 1'b0;
  logic [3:0]  pos_ctrl;
  logic [7:0]  num_ctrl;

  typedef struct {
    logic [3:0] pos;
    logic [7:0] num;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  seg_scan_ctrl #(.SCAN_DIV(4)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .src0       (src0),
    .src1       (src1),
    .src2       (src2),
    .src3       (src3),
    .select_reg (select_reg),
    .blank_lz   (blank_lz),
    .pos_ctrl   (pos_ctrl),
    .num_ctrl   (num_ctrl)
  );

  always #5 CLK = ~CLK;

  // cycles since reset release; display of frame f starts at cyc 16f+5
  always @(posedge CLK) begin
    if (Reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // push the four expected digit slots of one frame
  function automatic void push_frame(
    input logic [15:0] v,
    input logic [1:0]  sel,
    input logic        blz
  );
    exp_t e;
    logic [3:0] n;
    logic [6:0] s;
    logic       bl;
    for (int k = 0; k < 4; k++) begin
      n  = 4'((v >> (4 * k)) & 16'hF);
      bl = blz && (k >= 1) && (int'(v) < (1 << (4 * k)));
      s  = bl ? 7'h7F : ref_seg(n);
      e.pos = ~(4'b0001 << k);
      e.num = {(k != int'(sel)), s};
      sb.push_back(e);
    end
  endfunction

  // move to the first negedge of the frame snapshotted after now
  task automatic next_frame();
    int n = 0;
    @(negedge CLK);
    while ((cyc % 16) != 4 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if ((cyc % 16) != 4) begin
      failures++;
      $display("FAIL frame_sync: cyc=%0d want cyc%%16=4", cyc);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    exp_t e;
    src0 = 16'habc7;
    select_reg = 2'd0;
    blank_lz = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (pos_ctrl !== 4'hF || num_ctrl !== 8'hFF) begin
      failures++;
      $display("FAIL reset_hold: pos=%b num=%h want 1111 ff",
               pos_ctrl, num_ctrl);
    end
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if (pos_ctrl !== 4'hF || num_ctrl !== 8'hFF) begin
        failures++;
        $display("FAIL reset_dark c%0d: pos=%b num=%h want 1111 ff",
                 c, pos_ctrl, num_ctrl);
      end
    end
    @(negedge CLK);
    push_frame(16'habc7, 2'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pos_ctrl !== e.pos || num_ctrl !== e.num) begin
      failures++;
      $display("FAIL reset_first: pos=%b num=%h want %b %h",
               pos_ctrl, num_ctrl, e.pos, e.num);
    end
    sb.delete();
  endtask

  task automatic test_walk();
    exp_t e;
    src0 = 16'habc7;
    select_reg = 2'd0;
    blank_lz = 1'b0;
    push_frame(16'habc7, 2'd0, 1'b0);
    push_frame(16'habc7, 2'd0, 1'b0);
    next_frame();
    for (int s = 0; s < 8; s++) begin
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (pos_ctrl !== e.pos || num_ctrl !== e.num) begin
          failures++;
          $display("FAIL walk s%0d c%0d: pos=%b num=%h want %b %h",
                   s, c, pos_ctrl, num_ctrl, e.pos, e.num);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_midframe();
    exp_t e;
    push_frame(16'habc7, 2'd0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      if (s == 2) begin
        select_reg = 2'd2;
        src2 = 16'h1234;
        src0 = 16'hffff;
        push_frame(16'h1234, 2'd2, 1'b0);
      end
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (pos_ctrl !== e.pos || num_ctrl !== e.num) begin
          failures++;
          $display("FAIL mid_old s%0d c%0d: pos=%b num=%h want %b %h",
                   s, c, pos_ctrl, num_ctrl, e.pos, e.num);
        end
        @(negedge CLK);
      end
    end
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (pos_ctrl !== e.pos || num_ctrl !== e.num) begin
          failures++;
          $display("FAIL mid_new s%0d c%0d: pos=%b num=%h want %b %h",
                   s, c, pos_ctrl, num_ctrl, e.pos, e.num);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_blank();
    exp_t e;
    logic [15:0] vals [4];
    logic [1:0]  sels [4];
    vals[0] = 16'h0005; sels[0] = 2'd0;
    vals[1] = 16'h0000; sels[1] = 2'd0;
    vals[2] = 16'h0100; sels[2] = 2'd0;
    vals[3] = 16'h0050; sels[3] = 2'd3;
    blank_lz = 1'b1;
    for (int t = 0; t < 4; t++) begin
      src0 = vals[t];
      src3 = vals[t];
      select_reg = sels[t];
      push_frame(vals[t], sels[t], 1'b1);
      next_frame();
      for (int s = 0; s < 4; s++) begin
        e = sb.pop_front();
        for (int c = 0; c < 4; c++) begin
          checks++;
          if (pos_ctrl !== e.pos || num_ctrl !== e.num) begin
            failures++;
            $display("FAIL blank t%0d s%0d: pos=%b num=%h want %b %h",
                     t, s, pos_ctrl, num_ctrl, e.pos, e.num);
          end
          @(negedge CLK);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    blank_lz = 1'b0;
    select_reg = 2'd0;
    src0 = 16'h0009;
    next_frame();
    repeat (8) @(negedge CLK);
    checks++;
    if (pos_ctrl !== 4'b1011) begin
      failures++;
      $display("FAIL rmid_digit2: pos=%b want 1011", pos_ctrl);
    end
    Reset = 1'b1;
    @(negedge CLK);
    checks++;
    if (pos_ctrl !== 4'hF || num_ctrl !== 8'hFF) begin
      failures++;
      $display("FAIL rmid_dark: pos=%b num=%h want 1111 ff",
               pos_ctrl, num_ctrl);
    end
    @(negedge CLK);
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if (pos_ctrl !== 4'hF || num_ctrl !== 8'hFF) begin
        failures++;
        $display("FAIL rmid_wait c%0d: pos=%b num=%h want 1111 ff",
                 c, pos_ctrl, num_ctrl);
      end
    end
    @(negedge CLK);
    push_frame(16'h0009, 2'd0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (pos_ctrl !== e.pos || num_ctrl !== e.num) begin
          failures++;
          $display("FAIL rmid_fresh s%0d c%0d: pos=%b num=%h want %b %h",
                   s, c, pos_ctrl, num_ctrl, e.pos, e.num);
        end
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_midframe();
    test_blank();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
